parking_occupancy_counter: RTL and testbench

Occupancy tracker for a multi-lane parking lot. Each cycle it accepts per-lane entry and exit event pulses and applies their net effect to a saturating occupancy count bounded by CAPACITY. It also provides registered full/empty/almost-full status, sticky overflow/underflow error flags, a synchronous preset load and a peak-occupancy register. It sits between the per-lane sensor/FSM front ends and the display/gate-control logic.

---
 rtl/parking_occupancy_counter_if.sv | 27 ++
 rtl/parking_occupancy_counter.sv | 62 ++++++
 tb/tb_parking_occupancy_counter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/parking_occupancy_counter_if.sv
// parking_occupancy_counter_if: event/preset/error-clear controls in (incr, decr, load, load_value, clear_err, clear_peak); occupancy and status out (count, full, empty, almost_full, ovf_err, unf_err, peak)
interface parking_occupancy_counter_if #(
  parameter int N_LANES = 2,
  parameter int CNT_W   = 5
);
  logic [N_LANES-1:0] incr;
  logic [N_LANES-1:0] decr;
  logic               load;
  logic [CNT_W-1:0]   load_value;
  logic               clear_err;
  logic               clear_peak;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               almost_full;
  logic               ovf_err;
  logic               unf_err;
  logic [CNT_W-1:0]   peak;
  modport master (
    output incr, decr, load, load_value, clear_err, clear_peak,
    input  count, full, empty, almost_full, ovf_err, unf_err, peak
  );
  modport slave (
    input  incr, decr, load, load_value, clear_err, clear_peak,
    output count, full, empty, almost_full, ovf_err, unf_err, peak
  );
endinterface

// File: rtl/parking_occupancy_counter.sv
// parking_occupancy_counter: saturating multi-lane occupancy count with registered status, sticky errors and peak; ports clk, reset (async high), bus (slave modport)
module parking_occupancy_counter #(
  parameter int CAPACITY      = 16,
  parameter int N_LANES       = 2,
  parameter int ALMOST_MARGIN = 2
) (
  input logic                       clk,
  input logic                       reset,
  parking_occupancy_counter_if.slave bus
);
  localparam int CNT_W = $clog2(CAPACITY + 1);
  // wide enough that count plus/minus a full lane popcount never wraps
  localparam int SW = CNT_W + $clog2(N_LANES + 1) + 2;
  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ALM = CNT_W'(CAPACITY - ALMOST_MARGIN);
  localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);
  logic [CNT_W-1:0] count_q, count_d, peak_q, peak_d;
  logic full_q, full_d, empty_q, empty_d, almost_q, almost_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic signed [SW-1:0] next_s;
  logic ovf_new, unf_new;
  always_comb begin
    next_s  = $signed(SW'(count_q)) + $signed(SW'($countones(bus.incr))) - $signed(SW'($countones(bus.decr)));
    ovf_new = bus.load ? (bus.load_value > CAP) : (next_s > CAP_S);
    unf_new = !bus.load && next_s[SW-1];
    count_d = bus.load ? (ovf_new ? CAP : bus.load_value)
            : ovf_new ? CAP : unf_new ? '0 : next_s[CNT_W-1:0];
    // a fresh error in the clearing cycle keeps the flag set
    ovf_d    = ovf_new || (ovf_q && !bus.clear_err);
    unf_d    = unf_new || (unf_q && !bus.clear_err);
    peak_d   = (bus.clear_peak || count_d > peak_q) ? count_d : peak_q;
    full_d   = count_d == CAP;
    empty_d  = count_d == '0;
    almost_d = count_d >= ALM;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      peak_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      almost_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      peak_q   <= peak_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      almost_q <= almost_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end
  assign bus.count       = count_q;
  assign bus.peak        = peak_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.almost_full = almost_q;
  assign bus.ovf_err     = ovf_q;
  assign bus.unf_err     = unf_q;
endmodule

// File: tb/tb_parking_occupancy_counter.sv
// tb_parking_occupancy_counter: scoreboard-driven check of parking_occupancy_counter
module tb_parking_occupancy_counter;
  localparam int CAP = 16;
  localparam int NL  = 2;
  localparam int AM  = 2;
  localparam int CW  = $clog2(CAP + 1);
  typedef logic [2*CW+4:0] vec_t;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  parking_occupancy_counter_if #(.N_LANES(NL), .CNT_W(CW)) bus();
  parking_occupancy_counter #(.CAPACITY(CAP), .N_LANES(NL), .ALMOST_MARGIN(AM)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  int n_checks = 0;
  int n_fail = 0;
  int m_cnt = 0;
  int m_peak = 0;
  bit m_ovf = 0;
  bit m_unf = 0;
  vec_t sb[$];
  function automatic vec_t pack(int c, int p, bit o, bit u);
    return {CW'(c), c == CAP, c == 0, c >= CAP - AM, o, u, CW'(p)};
  endfunction
  function automatic vec_t actual();
    return {bus.count, bus.full, bus.empty, bus.almost_full, bus.ovf_err, bus.unf_err, bus.peak};
  endfunction
  task automatic model_reset();
    m_cnt = 0; m_peak = 0; m_ovf = 0; m_unf = 0;
    sb.delete();
  endtask
  task automatic drive(input logic [NL-1:0] i, input logic [NL-1:0] d, input logic ld,
                       input int lv, input logic ce, input logic cp);
    int nx;
    bit no, nu;
    bus.incr = i; bus.decr = d; bus.load = ld; bus.load_value = CW'(lv);
    bus.clear_err = ce; bus.clear_peak = cp;
    if (ld) begin
      no = lv > CAP; nu = 0; nx = no ? CAP : lv;
    end else begin
      nx = m_cnt + $countones(i) - $countones(d);
      no = nx > CAP; nu = nx < 0;
      nx = no ? CAP : (nu ? 0 : nx);
    end
    m_ovf = no || (m_ovf && !ce);
    m_unf = nu || (m_unf && !ce);
    m_peak = (cp || nx > m_peak) ? nx : m_peak;
    m_cnt = nx;
    sb.push_back(pack(m_cnt, m_peak, m_ovf, m_unf));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    vec_t e;
    bus.incr = '0; bus.decr = '0; bus.load = 0; bus.load_value = '0;
    bus.clear_err = 0; bus.clear_peak = 0;
    reset = 1;
    model_reset();
    repeat (2) tick();
    e = pack(0, 0, 0, 0);
    n_checks++;
    if (actual() !== e) begin n_fail++; $display("FAIL reset got %h exp %h", actual(), e); end
    @(negedge clk);
    reset = 0;
  endtask
  task automatic test_fill();
    vec_t e;
    for (int k = 0; k < 18; k++) begin
      drive(2'b01, 2'b00, 0, 0, 0, 0);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (actual() !== e) begin n_fail++; $display("FAIL fill[%0d] got %h exp %h", k, actual(), e); end
    end
  endtask
  task automatic test_drain();
    vec_t e;
    for (int k = 0; k < 19; k++) begin
      if (k == 0) drive(2'b00, 2'b00, 0, 0, 1, 0);
      else drive(2'b00, 2'b01, 0, 0, 0, 0);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (actual() !== e) begin n_fail++; $display("FAIL drain[%0d] got %h exp %h", k, actual(), e); end
    end
  endtask
  task automatic test_cancel();
    vec_t e;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: drive(2'b00, 2'b00, 1, 5, 1, 0);
        1: drive(2'b11, 2'b01, 0, 0, 0, 0);
        default: drive(2'b11, 2'b11, 0, 0, 0, 0);
      endcase
      tick();
      e = sb.pop_front();
      n_checks++;
      if (actual() !== e) begin n_fail++; $display("FAIL cancel[%0d] got %h exp %h", k, actual(), e); end
    end
  endtask
  task automatic test_ovf_clear();
    vec_t e;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: drive(2'b00, 2'b00, 1, 15, 1, 0);
        1: drive(2'b11, 2'b00, 0, 0, 0, 0);
        default: drive(2'b01, 2'b00, 0, 0, 1, 0);
      endcase
      tick();
      e = sb.pop_front();
      n_checks++;
      if (actual() !== e) begin n_fail++; $display("FAIL ovf_clear[%0d] got %h exp %h", k, actual(), e); end
    end
  endtask
  task automatic test_load();
    vec_t e;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: drive(2'b00, 2'b00, 0, 0, 1, 0);
        1: drive(2'b11, 2'b00, 1, 20, 0, 0);
        2: drive(2'b00, 2'b11, 1, 3, 0, 0);
        default: drive(2'b00, 2'b00, 0, 0, 0, 1);
      endcase
      tick();
      e = sb.pop_front();
      n_checks++;
      if (actual() !== e) begin n_fail++; $display("FAIL load[%0d] got %h exp %h", k, actual(), e); end
    end
  endtask
  task automatic test_async_reset();
    vec_t e;
    drive(2'b00, 2'b00, 1, 9, 1, 1);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (actual() !== e) begin n_fail++; $display("FAIL areset_pre got %h exp %h", actual(), e); end
    @(negedge clk);
    bus.load = 0; bus.incr = 2'b11; bus.decr = 2'b00; bus.clear_err = 0; bus.clear_peak = 0;
    reset = 1;
    model_reset();
    #1;
    e = pack(0, 0, 0, 0);
    n_checks++;
    if (actual() !== e) begin n_fail++; $display("FAIL areset_now got %h exp %h", actual(), e); end
    repeat (2) tick();
    n_checks++;
    if (actual() !== e) begin n_fail++; $display("FAIL areset_hold got %h exp %h", actual(), e); end
    @(negedge clk);
    reset = 0;
    drive(2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (actual() !== e) begin n_fail++; $display("FAIL areset_post got %h exp %h", actual(), e); end
  endtask
  task automatic test_back_to_back();
    vec_t e;
    for (int k = 0; k < 60; k++) begin
      drive(NL'($urandom), NL'($urandom), $urandom_range(0, 9) == 0, int'($urandom_range(0, 31)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (actual() !== e) begin n_fail++; $display("FAIL b2b[%0d] got %h exp %h", k, actual(), e); end
    end
  endtask
  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_cancel();
    test_ovf_clear();
    test_load();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
